// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester single-port RAM arbiter.
package mem_arb_pkg;
  localparam int NUM_REQ = 2;

  typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant select. MEM_ARB_ROUND_ROBIN_EN: ties go to the requester
// not granted last; otherwise requester 0 always wins ties.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_valid,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  req_id_t            i_last,
`endif
  output logic [NUM_REQ-1:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    if (i_valid == 2'b11) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      o_gnt = (i_last == 1'b0) ? 2'b10 : 2'b01;
`else
      o_gnt = 2'b01;
`endif
    end else begin
      o_gnt = i_valid;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with registered read data.
// Tie policy selected by MEM_ARB_ROUND_ROBIN_EN (undefined: fixed priority to requester 0).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic                            mem_we,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_rdata
);

  state_t                r_state, w_state_nxt;
  logic                  r_live;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  req_id_t               r_owner;
  logic [NUM_REQ-1:0]    w_gnt;
  logic                  w_hs;
  req_id_t               w_id;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_id_t               r_last;

  mem_arb_grant u_grant (
    .i_valid (req_valid),
    .i_last  (r_last),
    .o_gnt   (w_gnt)
  );
`else
  mem_arb_grant u_grant (
    .i_valid (req_valid),
    .o_gnt   (w_gnt)
  );
`endif

  // r_live holds ready low for the first cycle out of reset.
  assign req_ready = (r_live && r_state != ACCESS) ? w_gnt : '0;
  assign w_hs      = |(req_valid & req_ready);
  assign w_id      = w_gnt[1];
  assign mem_addr  = r_addr;

  always_comb begin
    w_state_nxt = r_state;
    rsp_valid   = '0;
    rsp_rdata   = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    case (r_state)
      IDLE: begin
        if (w_hs) w_state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_we      = r_we;
        mem_wdata   = r_wdata;
        w_state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[r_owner] = 1'b1;
        rsp_rdata          = r_we ? '0 : mem_rdata;
        w_state_nxt        = w_hs ? ACCESS : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_live  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_owner <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_last  <= 1'b1;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      if (w_hs) begin
        r_we    <= req_we[w_id];
        r_addr  <= w_id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
        r_wdata <= w_id ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
        r_owner <= w_id;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        r_last  <= w_id;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a 4096x12 registered-read RAM model.
module tb_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [1:0]      req_we = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_we;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int            id;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int            id;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] ram [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] <= '0;
    ram[12'h010] <= 12'hABC;
  end
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid != 2'b00) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rsp_valid 0x%0h expected none", rsp_valid);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_owner", {30'b0, rsp_valid}, 32'(1 << e.id));
        chk("rsp_rdata", {20'b0, rsp_rdata}, {20'b0, e.rdata});
        chk("rsp_latency", cyc, e.cyc);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sbq.size(), 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 2'b01;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {30'b0, req_ready}, 0);
    chk("rst_rsp_valid", {30'b0, rsp_valid}, 0);
    chk("rst_rsp_rdata", {20'b0, rsp_rdata}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_mem_addr", {20'b0, mem_addr}, 0);
    chk("rst_mem_wdata", {20'b0, mem_wdata}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_cycle_ready", {30'b0, req_ready}, 0);
    req_valid = '0;
  endtask

  // Holds valid until the handshake, then scrambles the inputs so a late
  // change would corrupt the in-flight access.
  task automatic do_req(input vec_t v);
    int n = 0;
    bit got = 0;
    @(posedge clk); #1;
    req_valid[v.id] = 1'b1;
    req_we[v.id] = v.we;
    req_addr[v.id*AW +: AW] = v.addr;
    req_wdata[v.id*DW +: DW] = v.wdata;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (req_ready[v.id]) begin
        got = 1;
        sbq.push_back('{v.id, v.exp, cyc + 2});
      end
    end
    chk("handshake", {31'b0, got}, 1);
    @(posedge clk); #1;
    req_valid[v.id] = 1'b0;
    req_we[v.id] = ~v.we;
    req_addr[v.id*AW +: AW] = ~v.addr;
    req_wdata[v.id*DW +: DW] = ~v.wdata;
  endtask

  initial begin
    vec_t vt[7];
    vec_t vr;
    logic [AW-1:0] ba[3];
    logic [DW-1:0] bd[3];
    int hs[3];
    int order[4];
    int exp_order[4];
    int k;
    int n;
    int id;

    vt[0] = '{0, 1'b0, 12'h010, 12'h000, 12'hABC};
    vt[1] = '{1, 1'b1, 12'h0FF, 12'h123, 12'h000};
    vt[2] = '{1, 1'b0, 12'h0FF, 12'h000, 12'h123};
    vt[3] = '{0, 1'b1, 12'h000, 12'hFFF, 12'h000};
    vt[4] = '{1, 1'b0, 12'h000, 12'h000, 12'hFFF};
    vt[5] = '{0, 1'b1, 12'hFFF, 12'h800, 12'h000};
    vt[6] = '{0, 1'b0, 12'hFFF, 12'h000, 12'h800};

    apply_reset();

    for (int i = 0; i < 7; i++) begin
      do_req(vt[i]);
      drain();
      chk("idle_mem_we", {31'b0, mem_we}, 0);
      chk("idle_mem_wdata", {20'b0, mem_wdata}, 0);
      chk("idle_mem_addr_hold", {20'b0, mem_addr}, {20'b0, vt[i].addr});
    end

    // Back-to-back reads from requester 0 with valid held high.
    ba[0] = 12'h010; bd[0] = 12'hABC;
    ba[1] = 12'h0FF; bd[1] = 12'h123;
    ba[2] = 12'h000; bd[2] = 12'hFFF;
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    req_we[0] = 1'b0;
    req_addr[AW-1:0] = ba[0];
    k = 0;
    n = 0;
    while (k < 3 && n < 30) begin
      @(negedge clk);
      n++;
      if (req_ready[0]) begin
        hs[k] = cyc;
        sbq.push_back('{0, bd[k], cyc + 2});
        k++;
        @(posedge clk); #1;
        if (k < 3) req_addr[AW-1:0] = ba[k];
        else req_valid[0] = 1'b0;
      end
    end
    chk("b2b_count", k, 3);
    if (k == 3) begin
      chk("b2b_gap1", hs[1] - hs[0], 2);
      chk("b2b_gap2", hs[2] - hs[1], 2);
    end
    drain();

    // Reset while the access is in flight: no completion, outputs cleared.
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    req_we[0] = 1'b1;
    req_addr[AW-1:0] = 12'h055;
    req_wdata[DW-1:0] = 12'h5A5;
    n = 0;
    while (!req_ready[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_handshake", {31'b0, req_ready[0]}, 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("access_mem_we", {31'b0, mem_we}, 1);
    chk("access_mem_addr", {20'b0, mem_addr}, 32'h055);
    chk("access_mem_wdata", {20'b0, mem_wdata}, 32'h5A5);
    chk("access_ready", {30'b0, req_ready}, 0);
    rst_n = 1'b0;
    req_valid[0] = 1'b1;
    req_we[0] = 1'b0;
    req_addr[AW-1:0] = 12'h010;
    #1;
    chk("abort_ready", {30'b0, req_ready}, 0);
    chk("abort_rsp_valid", {30'b0, rsp_valid}, 0);
    chk("abort_rsp_rdata", {20'b0, rsp_rdata}, 0);
    chk("abort_mem_we", {31'b0, mem_we}, 0);
    chk("abort_mem_addr", {20'b0, mem_addr}, 0);
    chk("abort_mem_wdata", {20'b0, mem_wdata}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_first_cycle_ready", {30'b0, req_ready}, 0);
    req_valid[0] = 1'b0;
    vr = '{0, 1'b0, 12'h010, 12'h000, 12'hABC};
    do_req(vr);
    drain();

    // Continuous tie from a fresh reset.
    apply_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    @(posedge clk); #1;
    req_valid = 2'b11;
    req_we = 2'b00;
    req_addr = {12'h0FF, 12'h010};
    k = 0;
    n = 0;
    while (k < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (req_ready != 2'b00) begin
        chk("tie_ready_onehot", $countones(req_ready), 1);
        id = req_ready[1] ? 1 : 0;
        order[k] = id;
        sbq.push_back('{id, (id == 1) ? 12'h123 : 12'hABC, cyc + 2});
        k++;
        if (k == 4) begin
          @(posedge clk); #1;
          req_valid = 2'b00;
        end
      end
    end
    chk("tie_count", k, 4);
    if (k == 4) begin
      for (int i = 0; i < 4; i++) chk("tie_grant_order", order[i], exp_order[i]);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 12, memory word width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 2, per-requester request valid (bit N = requester N).
REQ-006 SHALL have port req_ready, output, 2, per-requester request accepted this cycle.
REQ-007 SHALL have port req_we, input, 2, per-requester write (1) / read (0).
REQ-008 SHALL have port req_addr, input, 2xADDR_WIDTH, per-requester address.
REQ-009 SHALL have port req_wdata, input, 2xDATA_WIDTH, per-requester write data.
REQ-010 SHALL have port rsp_valid, output, 2, one-cycle completion pulse to the owning requester.
REQ-011 SHALL have port rsp_rdata, output, DATA_WIDTH, read data, qualified by rsp_valid.
REQ-012 SHALL have port mem_addr, output, ADDR_WIDTH, address to the single-port RAM.
REQ-013 SHALL have port mem_we, output, 1, RAM write enable.
REQ-014 SHALL have port mem_wdata, output, DATA_WIDTH, RAM write data.
REQ-015 SHALL have port mem_rdata, input, DATA_WIDTH, RAM registered read data (valid one cycle after address, when mem_we=0).

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-017 IDLE: req_ready asserted to at most one requester, the grantee per REQ-023; a handshake (valid & ready) captures we/addr/wdata/owner into registers -> ACCESS; no valid -> stay IDLE.
REQ-018 ACCESS: mem_addr/mem_we/mem_wdata driven from the captured registers; req_ready = 0; -> RESP unconditionally.
REQ-019 RESP: rsp_valid[owner] = 1 for exactly this cycle; rsp_rdata = mem_rdata for reads, 0 for writes; req_ready granted as in IDLE; a handshake here -> ACCESS (back-to-back), else -> IDLE.
REQ-020 Latency: handshake at cycle T -> rsp_valid at T+2; peak throughput one access per 2 cycles.
REQ-021 Outside ACCESS: mem_we = 0, mem_addr holds the last captured address, mem_wdata = 0.
REQ-022 rsp_valid SHALL never assert for both bits; rsp_valid = 0 in IDLE and ACCESS.
REQ-023 Grant: only one valid -> that requester; both valid -> arbitration per Configuration.
REQ-024 Requester inputs SHALL be sampled only at handshake; changes after handshake do not affect the in-flight access.
REQ-025 A requester deasserting valid without handshake SHALL not be penalised; no request is ever dropped once accepted.

Reset
REQ-026 On rst_n low, asynchronously: state = IDLE, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, captured registers = 0, last-grant pointer = 1 (so requester 0 wins first tie).
REQ-027 Reset mid-access SHALL abort the access with no rsp_valid; requester must reissue.
REQ-028 req_ready SHALL stay 0 in the first cycle after rst_n deasserts, then follow REQ-017.

Configuration
REQ-029 Macro MEM_ARB_ROUND_ROBIN_EN defined: on tie, grant the requester not granted last; pointer updates on every handshake.
REQ-030 Macro undefined: fixed priority, requester 0 always wins ties; pointer logic absent.

Structure
REQ-031 Shared package mem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), NUM_REQ = 2 and the requester-id typedef.
REQ-032 One sub-module, mem_arb_grant (combinational grant selection from valid + pointer), is natural; FSM and capture registers stay in mem_arbiter.
REQ-033 Bench SHALL instantiate mem_arbiter with the 4096x12 RAM model as mem_* partner.

Verification
REQ-034 Single read: req0 read addr 0x010 (RAM preloaded 0x010=0xABC) -> rsp_valid=2'b01 at T+2, rsp_rdata=0xABC.
REQ-035 Write then read: req1 write 0x0FF<=0x123, then req1 read 0x0FF -> second rsp_rdata=0x123, first rsp_rdata=0.
REQ-036 Tie: both valid continuously, 4 accesses -> RR_EN: grants 0,1,0,1; undefined: 0,0,0,0.
REQ-037 Back-to-back: req0 holds valid with 3 reads -> handshakes at T, T+2, T+4; rsp_valid at T+2, T+4, T+6.
REQ-038 Reset in ACCESS: rst_n low one cycle -> no rsp_valid, all outputs at REQ-026 values, next access completes normally.
